// File: rtl/traffic_phase_decoder.sv
// traffic_phase_decoder: decodes the sampled cycle count into NS/EW light phases, serves pedestrian requests,
// flags count-sequence breaks. Optional feature macro: PEDESTRIAN_WALK_EN (walk/ped_ack/pending latch).
`default_nettype none

module traffic_phase_decoder #(
  parameter int N        = 6,
  parameter int LAST     = 53,
  parameter int NS_G_END = 23,
  parameter int NS_Y_END = 26,
  parameter int EW_G_END = 50,
  parameter int WALK_END = 46
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] i_count,
  input  logic         i_ped_req,
  output logic [2:0]   o_ns_light,
  output logic [2:0]   o_ew_light,
  output logic         o_walk,
  output logic         o_ped_ack,
  output logic         o_seq_err
);

  localparam logic [N-1:0] c_LAST     = N'(LAST);
  localparam logic [N-1:0] c_NS_G_END = N'(NS_G_END);
  localparam logic [N-1:0] c_NS_Y_END = N'(NS_Y_END);
  localparam logic [N-1:0] c_EW_G_END = N'(EW_G_END);
  localparam logic [N-1:0] c_WALK_CLR = N'(WALK_END + 1);

  localparam logic [2:0] c_RED = 3'b100;
  localparam logic [2:0] c_YEL = 3'b010;
  localparam logic [2:0] c_GRN = 3'b001;

  typedef enum logic [2:0] {
    S_SYNC = 3'd0,
    S_NS_G = 3'd1,
    S_NS_Y = 3'd2,
    S_EW_G = 3'd3,
    S_EW_Y = 3'd4
  } state_t;

  state_t       r_state;
  state_t       w_phase;
  state_t       w_next;
  logic [N-1:0] r_prev;
  logic [N-1:0] w_expect;
  logic         w_seq_ok;
  logic         w_err;
  logic         w_enter_ewg;
  logic [2:0]   r_ns_light;
  logic [2:0]   r_ew_light;
  logic         r_seq_err;

  always_comb begin
    w_expect = (r_prev == c_LAST) ? '0 : r_prev + 1'b1;
    w_seq_ok = (i_count == w_expect) && (i_count <= c_LAST);

    if (i_count <= c_NS_G_END)      w_phase = S_NS_G;
    else if (i_count <= c_NS_Y_END) w_phase = S_NS_Y;
    else if (i_count <= c_EW_G_END) w_phase = S_EW_G;
    else                            w_phase = S_EW_Y;

    w_err  = 1'b0;
    w_next = S_SYNC;
    if (r_state == S_SYNC) begin
      w_next = (i_count == '0) ? S_NS_G : S_SYNC;
    end else if (w_seq_ok) begin
      w_next = w_phase;
    end else begin
      w_err = 1'b1;
    end
    w_enter_ewg = (w_next == S_EW_G) && (r_state != S_EW_G);
  end

`ifdef PEDESTRIAN_WALK_EN
  logic r_ped_pend;
  logic r_walk;
  logic r_ped_ack;
`else
  logic w_unused_ped;
  assign w_unused_ped = i_ped_req ^ w_enter_ewg;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_SYNC;
      r_prev     <= '0;
      r_ns_light <= c_RED;
      r_ew_light <= c_RED;
      r_seq_err  <= 1'b0;
`ifdef PEDESTRIAN_WALK_EN
      r_ped_pend <= 1'b0;
      r_walk     <= 1'b0;
      r_ped_ack  <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      r_prev  <= i_count;
      if (w_err) r_seq_err <= 1'b1;

      case (w_next)
        S_NS_G:  begin r_ns_light <= c_GRN; r_ew_light <= c_RED; end
        S_NS_Y:  begin r_ns_light <= c_YEL; r_ew_light <= c_RED; end
        S_EW_G:  begin r_ns_light <= c_RED; r_ew_light <= c_GRN; end
        S_EW_Y:  begin r_ns_light <= c_RED; r_ew_light <= c_YEL; end
        default: begin r_ns_light <= c_RED; r_ew_light <= c_RED; end
      endcase

`ifdef PEDESTRIAN_WALK_EN
      // A request arriving on the entry edge itself is served in this phase.
      r_ped_ack <= 1'b0;
      if (w_enter_ewg && (r_ped_pend || i_ped_req)) begin
        r_ped_pend <= 1'b0;
        r_ped_ack  <= 1'b1;
        r_walk     <= 1'b1;
      end else begin
        r_ped_pend <= r_ped_pend | i_ped_req;
        if (w_err || (i_count == c_WALK_CLR)) r_walk <= 1'b0;
      end
`endif
    end
  end

  assign o_ns_light = r_ns_light;
  assign o_ew_light = r_ew_light;
  assign o_seq_err  = r_seq_err;
`ifdef PEDESTRIAN_WALK_EN
  assign o_walk     = r_walk;
  assign o_ped_ack  = r_ped_ack;
`else
  assign o_walk     = 1'b0;
  assign o_ped_ack  = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_traffic_phase_decoder.sv
// tb_traffic_phase_decoder: directed and randomized scenarios checked against a phase-table reference model.
`default_nettype none

module tb_traffic_phase_decoder;

`ifdef PEDESTRIAN_WALK_EN
  localparam bit PED = 1'b1;
`else
  localparam bit PED = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] i_count = 6'd40;
  logic       i_ped_req = 1'b0;
  logic [2:0] o_ns_light, o_ew_light;
  logic       o_walk, o_ped_ack, o_seq_err;

  int total = 0;
  int bad   = 0;

  traffic_phase_decoder dut (
    .clk        (clk),
    .rst        (rst),
    .i_count    (i_count),
    .i_ped_req  (i_ped_req),
    .o_ns_light (o_ns_light),
    .o_ew_light (o_ew_light),
    .o_walk     (o_walk),
    .o_ped_ack  (o_ped_ack),
    .o_seq_err  (o_seq_err)
  );

  always #5 clk = ~clk;

  wire [8:0] w_obs = {o_ns_light, o_ew_light, o_walk, o_ped_ack, o_seq_err};

  // Reference model: "synced" flag, last sample, sticky error, pedestrian bookkeeping.
  bit m_synced, m_err, m_pend, m_walk, m_ack;
  int m_prev;

  task automatic model_reset();
    m_synced = 0; m_err = 0; m_pend = 0; m_walk = 0; m_ack = 0; m_prev = 0;
  endtask

  task automatic model_edge(input int c, input bit req);
    int nxt;
    nxt   = (m_prev == 53) ? 0 : m_prev + 1;
    m_ack = 0;
    if (!m_synced) begin
      if (c == 0) m_synced = 1;
    end else if (c != nxt) begin
      m_err = 1; m_synced = 0; m_walk = 0;
    end
    if (PED) begin
      if (m_synced && c == 27 && (m_pend || req)) begin
        m_ack = 1; m_walk = 1; m_pend = 0;
      end else begin
        m_pend = m_pend | req;
      end
      if (m_synced && c == 47) m_walk = 0;
    end
    m_prev = c;
  endtask

  function automatic logic [8:0] exp_vec();
    logic [2:0] ns, ew;
    if (!m_synced)          begin ns = 3'b100; ew = 3'b100; end
    else if (m_prev <= 23)  begin ns = 3'b001; ew = 3'b100; end
    else if (m_prev <= 26)  begin ns = 3'b010; ew = 3'b100; end
    else if (m_prev <= 50)  begin ns = 3'b100; ew = 3'b001; end
    else                    begin ns = 3'b100; ew = 3'b010; end
    return {ns, ew, m_walk, m_ack, m_err};
  endfunction

  task automatic drive_step(input int c, input bit req);
    @(negedge clk);
    i_count   = 6'(c);
    i_ped_req = req;
    @(posedge clk);
    #1;
    model_edge(c, req);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; i_count = 6'd40; i_ped_req = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (w_obs !== exp_vec()) begin bad++; $display("FAIL reset obs=%b exp=%b", w_obs, exp_vec()); end
    for (int i = 0; i < 4; i++) begin
      drive_step(5 + i, 1'b0);
      total++;
      if (w_obs !== exp_vec()) begin bad++; $display("FAIL reset_hold cnt=%0d obs=%b exp=%b", i_count, w_obs, exp_vec()); end
    end
  endtask

  task automatic test_full_cycle();
    do_reset();
    for (int i = 0; i < 54 + 6; i++) begin
      drive_step(i % 54, 1'b0);
      total++;
      if (w_obs !== exp_vec()) begin bad++; $display("FAIL full_cycle cnt=%0d obs=%b exp=%b", i_count, w_obs, exp_vec()); end
    end
  endtask

  task automatic test_release_mid();
    do_reset();
    for (int i = 10; i < 54 + 4; i++) begin
      drive_step(i % 54, 1'b0);
      total++;
      if (w_obs !== exp_vec()) begin bad++; $display("FAIL release_mid cnt=%0d obs=%b exp=%b", i_count, w_obs, exp_vec()); end
    end
  endtask

  task automatic test_ped_early();
    do_reset();
    for (int i = 0; i < 54 + 3; i++) begin
      drive_step(i % 54, i == 5);
      total++;
      if (w_obs !== exp_vec()) begin bad++; $display("FAIL ped_early cnt=%0d obs=%b exp=%b", i_count, w_obs, exp_vec()); end
      if (i == 27 || i == 46) begin
        total++;
        if (o_walk !== PED) begin bad++; $display("FAIL ped_early_walk cnt=%0d walk=%b exp=%b", i, o_walk, PED); end
      end
    end
  endtask

  task automatic test_ped_late();
    do_reset();
    for (int i = 0; i < 54 + 51; i++) begin
      drive_step(i % 54, i == 30);
      total++;
      if (w_obs !== exp_vec()) begin bad++; $display("FAIL ped_late cnt=%0d obs=%b exp=%b", i_count, w_obs, exp_vec()); end
    end
  endtask

  task automatic test_seq_jump();
    int seq[$];
    do_reset();
    for (int i = 0; i <= 12; i++) seq.push_back(i);
    for (int i = 14; i < 54; i++) seq.push_back(i);
    for (int i = 0; i <= 10; i++) seq.push_back(i);
    foreach (seq[k]) begin
      drive_step(seq[k], 1'b0);
      total++;
      if (w_obs !== exp_vec()) begin bad++; $display("FAIL seq_jump cnt=%0d obs=%b exp=%b", i_count, w_obs, exp_vec()); end
    end
    total++;
    if (o_seq_err !== 1'b1) begin bad++; $display("FAIL seq_err_sticky err=%b exp=1", o_seq_err); end
    do_reset();
    total++;
    if (w_obs !== exp_vec()) begin bad++; $display("FAIL seq_err_clear obs=%b exp=%b", w_obs, exp_vec()); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i <= 35; i++) begin
      drive_step(i, i == 5);
      total++;
      if (w_obs !== exp_vec()) begin bad++; $display("FAIL pre_rst cnt=%0d obs=%b exp=%b", i_count, w_obs, exp_vec()); end
    end
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    total++;
    if (w_obs !== exp_vec()) begin bad++; $display("FAIL async_rst obs=%b exp=%b", w_obs, exp_vec()); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i <= 30; i++) begin
      drive_step(i, 1'b0);
      total++;
      if (w_obs !== exp_vec()) begin bad++; $display("FAIL post_rst cnt=%0d obs=%b exp=%b", i_count, w_obs, exp_vec()); end
    end
  endtask

  task automatic test_random();
    int c;
    do_reset();
    c = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0) c = $urandom_range(0, 63);
      else                            c = (c >= 53) ? 0 : c + 1;
      drive_step(c, $urandom_range(0, 9) == 0);
      total++;
      if (w_obs !== exp_vec()) begin bad++; $display("FAIL random cnt=%0d obs=%b exp=%b", i_count, w_obs, exp_vec()); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_full_cycle();
    test_release_mid();
    test_ped_early();
    test_ped_late();
    test_seq_jump();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/traffic_phase_decoder.md
# traffic_phase_decoder

Consumer side of the traffic-controller cycle timer. Samples the free-running 6-bit cycle count (0..53, wrapping, updated on the falling clock edge) and decodes it into north-south and east-west light phases through a registered state machine. Also serves latched pedestrian requests and flags any break in the count sequence. Sits between the cycle counter and the lamp drivers.

## Interface
- N, 6, count width
- LAST, 53, final count value before wrap to 0
- NS_G_END, 23, last count of NS green (NS green = 0..23)
- NS_Y_END, 26, last count of NS yellow (24..26)
- EW_G_END, 50, last count of EW green (27..50); EW yellow = 51..LAST
- WALK_END, 46, last count with walk asserted

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- count  in  N  cycle count from the timer
- ped_req  in  1  pedestrian request, level, any time
- ns_light  out  3  one-hot {red,yellow,green}
- ew_light  out  3  one-hot {red,yellow,green}
- walk  out  1  pedestrian walk across the NS road
- ped_ack  out  1  one-cycle pulse when a pending request is served
- seq_err  out  1  sticky count-sequence error

## Operation
- States: SYNC, NS_G, NS_Y, EW_G, EW_Y.
- SYNC: both lights red (3'b100), no error checking. Leave SYNC only on a sampled count==0 -> NS_G.
- Synced states follow the sampled count: 0..NS_G_END NS_G; ..NS_Y_END NS_Y; ..EW_G_END EW_G; ..LAST EW_Y. The light not green/yellow is red.
- Sequence check (synced states only): each sample must equal previous+1, or 0 after LAST. Mismatch or count>LAST -> seq_err=1, state SYNC (both red), walk=0. seq_err clears only on rst.
- Pedestrian: ped_req sampled into ped_pend each edge. On the edge entering EW_G with ped_pend (or ped_req) high: ped_pend cleared, ped_ack pulses one cycle, walk=1 until the sample count==WALK_END+1, then 0. A request arriving after EW_G entry stays pending until the next EW_G entry.
- Simultaneous ped_req and EW_G entry: served in that phase.

## Timing
- Count changes on falling edge, sampled on next rising edge; all outputs registered, reflecting the phase of the count sampled at that edge (one rising-edge latency).
- Reset values: state SYNC, ns_light=ew_light=3'b100, walk=0, ped_ack=0, seq_err=0, ped_pend=0.
- Reset asserted mid-phase: outputs return to reset values immediately (asynchronous); pending request discarded.
- Wrap LAST->0: EW_Y -> NS_G in one edge, no error.
- Never both directions green/yellow simultaneously; lights always exactly one-hot.

## Configuration
- PEDESTRIAN_WALK_EN defined: pedestrian latch, walk and ped_ack as above.
- Not defined: ped_req ignored, walk and ped_ack tied 0, ped_pend not built; light sequencing unchanged.

## Test plan
- Reset, then counter from 0: samples 0 -> ns=001/ew=100; 24 -> ns=010; 27 -> ns=100/ew=001; 51 -> ew=010; 53->0 -> ns=001, seq_err=0.
- Counter released at 10 after reset: stays SYNC (both 100) until sample 0, then NS_G, no seq_err.
- ped_req pulse at count 5: ped_ack one cycle at sample 27, walk=1 for samples 27..46, 0 at 47.
- ped_req at count 30 (mid EW_G): no walk this cycle; served at next sample 27 with ped_ack.
- Count jump 12->14: seq_err=1, both lights 100 next edge; resync at next 0, seq_err stays 1 until rst.
- rst asserted at count 35 with walk high: walk=0, lights 100 immediately; without PEDESTRIAN_WALK_EN walk/ped_ack never assert.
